// File: rtl/fib_wb_pkg.sv
// Shared types and constants for the fibonacci Wishbone initiator: FSM state
// encoding, the slave's register map and its well-known data values.
package fib_wb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } wb_state_e;

   localparam logic [31:0] CTRL_GET_NR         = 32'h0000_0000;
   localparam logic [31:0] CTRL_GET_ID         = 32'h0000_0004;
   localparam logic [31:0] CTRL_SET_IRQ        = 32'h0000_0008;
   localparam logic [31:0] CTRL_FIBONACCI_CTRL = 32'h0000_000C;
   localparam logic [31:0] CTRL_CLOCK          = 32'h0000_0010;
   localparam logic [31:0] CTRL_FIBONACCI_VAL  = 32'h0000_0014;
   localparam logic [31:0] CTRL_WRITE          = 32'h0000_0018;
   localparam logic [31:0] CTRL_READ           = 32'h0000_001C;
   localparam logic [31:0] CTRL_PANIC          = 32'h0000_0020;

   localparam logic [31:0] CTRL_ID = 32'h4669_626f;
   localparam logic [31:0] ACK_OK  = 32'h0000_0001;
   localparam logic [31:0] ACK_OFF = 32'h0000_0000;

   localparam logic [3:0]  SEL_ALL = 4'hF;

   // Reads put zero on the write-data lines so a snooping analyzer sees no stale data.
   function automatic logic [31:0] bus_wr_data(input logic we, input logic [31:0] dat);
      return we ? dat : 32'h0;
   endfunction

endpackage

// File: rtl/fib_wb_master_if.sv
// Wishbone classic-cycle bus between the fibonacci initiator and its slave.
interface fib_wb_master_if #(
   parameter int ADR_W = 32
);
   logic             wbm_cyc_o;
   logic             wbm_stb_o;
   logic             wbm_we_o;
   logic [3:0]       wbm_sel_o;
   logic [ADR_W-1:0] wbm_adr_o;
   logic [31:0]      wbm_dat_o;
   logic             wbm_ack_i;
   logic [31:0]      wbm_dat_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );
endinterface

// File: rtl/fib_wb_poll_timer.sv
// Poll interval timer: saturating down-counter that reloads on request or while
// disabled, and flags when it has reached zero.
module fib_wb_poll_timer #(
   parameter int WIDTH  = 10,
   parameter int RELOAD = 1023
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic en,
   input  logic reload,
   output logic zero
);

   localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(RELOAD);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk_sys) begin
      if (rst || reload || !en) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/fib_wb_master.sv
// Wishbone classic-cycle initiator for the fibonacci slave: runs one transfer
// at a time from the command port or an autonomous poll, with a bus timeout.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no cycle open; accepts a command or issues a due poll read
//   ST_BUS  | cyc/stb asserted; waiting for ack or for the timeout abort
module fib_wb_master
   import fib_wb_pkg::*;
#(
   parameter int               ADR_W         = 32,
   parameter int               TIMEOUT       = 16,
   parameter logic [ADR_W-1:0] POLL_ADR      = ADR_W'(32'h0000_0014),
   parameter int               POLL_INTERVAL = 1024
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [ADR_W-1:0] cmd_adr,
   input  logic [31:0]      cmd_dat,
   input  logic [3:0]       cmd_sel,
   input  logic             poll_en,
   output logic             rsp_valid,
   output logic [31:0]      rsp_dat,
   output logic             rsp_err,
   output logic             rsp_poll,
   fib_wb_master_if.master  wb
);

   localparam int          POLL_W  = $clog2(POLL_INTERVAL);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   wb_state_e   state;
   wb_state_e   state_nxt;
   logic [15:0] to_cnt;
   logic        poll_flag;
   logic        poll_zero;
   logic        accept;
   logic        poll_go;
   logic        bus_ack;
   logic        bus_abort;

   fib_wb_poll_timer #(
      .WIDTH  (POLL_W),
      .RELOAD (POLL_INTERVAL - 1)
   ) u_poll_timer (
      .clk_sys (wb_clk_i),
      .rst     (wb_rst_i),
      .en      (poll_en),
      .reload  (poll_go),
      .zero    (poll_zero)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // A pending command always beats a due poll; the timer simply holds at zero.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      accept    = 1'b0;
      poll_go   = 1'b0;
      bus_ack   = 1'b0;
      bus_abort = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = !wb_rst_i;
            accept    = cmd_valid && !wb_rst_i;
            poll_go   = !cmd_valid && poll_en && poll_zero && !wb_rst_i;
            if (accept || poll_go) state_nxt = ST_BUS;
         end
         ST_BUS: begin
            if (wb.wbm_ack_i) begin
               bus_ack   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (to_cnt == TO_LAST) begin
               bus_abort = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb.wbm_cyc_o <= 1'b0;
         wb.wbm_stb_o <= 1'b0;
         wb.wbm_we_o  <= 1'b0;
         wb.wbm_sel_o <= 4'h0;
         wb.wbm_adr_o <= '0;
         wb.wbm_dat_o <= 32'h0;
         to_cnt       <= 16'h0;
         poll_flag    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_dat      <= 32'h0;
         rsp_err      <= 1'b0;
         rsp_poll     <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         if (accept) begin
            wb.wbm_cyc_o <= 1'b1;
            wb.wbm_stb_o <= 1'b1;
            wb.wbm_we_o  <= cmd_we;
            wb.wbm_sel_o <= cmd_sel;
            wb.wbm_adr_o <= cmd_adr;
            wb.wbm_dat_o <= bus_wr_data(cmd_we, cmd_dat);
            to_cnt       <= 16'h0;
            poll_flag    <= 1'b0;
         end else if (poll_go) begin
            wb.wbm_cyc_o <= 1'b1;
            wb.wbm_stb_o <= 1'b1;
            wb.wbm_we_o  <= 1'b0;
            wb.wbm_sel_o <= SEL_ALL;
            wb.wbm_adr_o <= POLL_ADR;
            wb.wbm_dat_o <= 32'h0;
            to_cnt       <= 16'h0;
            poll_flag    <= 1'b1;
         end else if (bus_ack) begin
            wb.wbm_cyc_o <= 1'b0;
            wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_dat      <= wb.wbm_we_o ? 32'h0 : wb.wbm_dat_i;
            rsp_err      <= 1'b0;
            rsp_poll     <= poll_flag;
         end else if (bus_abort) begin
            wb.wbm_cyc_o <= 1'b0;
            wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_dat      <= 32'h0;
            rsp_err      <= 1'b1;
            rsp_poll     <= poll_flag;
         end else if (state == ST_BUS) begin
            to_cnt <= to_cnt + 16'h1;
         end
      end
   end

endmodule

// File: tb/tb_fib_wb_master.sv
// Self-checking bench for fib_wb_master: register-map slave model, directed
// vector table, poll/collision/reset sequences and randomized transfers.
module tb_fib_wb_master;
   import fib_wb_pkg::*;

   localparam int TO = 16;
   localparam int PI = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        poll_en;
   logic        rsp_valid;
   logic [31:0] rsp_dat;
   logic        rsp_err, rsp_poll;

   fib_wb_master_if #(.ADR_W(32)) wb ();

   fib_wb_master #(
      .ADR_W(32), .TIMEOUT(TO), .POLL_ADR(32'h14), .POLL_INTERVAL(PI)
   ) dut (
      .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr  (cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .poll_en  (poll_en),
      .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .rsp_poll(rsp_poll),
      .wb       (wb)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Slave model: ID, fibonacci value (increments per read), write/read-back pair.
   logic        slv_noack, slv_spur;
   int          slv_delay;
   int          slv_wait  = 0;
   logic [31:0] slv_store = 32'h0;
   logic [31:0] slv_fib   = 32'h0;

   assign wb.wbm_ack_i = slv_spur |
      (wb.wbm_cyc_o & wb.wbm_stb_o & !slv_noack & (slv_wait >= slv_delay));

   always_comb begin
      wb.wbm_dat_i = ~wb.wbm_adr_o;
      case (wb.wbm_adr_o)
         CTRL_GET_ID:        wb.wbm_dat_i = CTRL_ID;
         CTRL_FIBONACCI_VAL: wb.wbm_dat_i = slv_fib;
         CTRL_READ:          wb.wbm_dat_i = slv_store;
         default:            ;
      endcase
   end

   always @(posedge wb_clk_i) begin
      if (wb.wbm_cyc_o && wb.wbm_stb_o && !wb.wbm_ack_i) slv_wait <= slv_wait + 1;
      else                                               slv_wait <= 0;
      if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_ack_i) begin
         if (wb.wbm_we_o && wb.wbm_adr_o == CTRL_WRITE) slv_store <= wb.wbm_dat_o;
         if (!wb.wbm_we_o && wb.wbm_adr_o == CTRL_FIBONACCI_VAL) slv_fib <= slv_fib + 32'h1;
      end
   end

   // Bus monitor: records each cycle's opening fields and stb length.
   int          mon_cycle = 0, mon_stb = 0, mon_start = 0, mon_bad = 0;
   logic        mon_prev = 1'b0, mon_we;
   logic [31:0] mon_adr, mon_dat;
   logic [3:0]  mon_sel;

   always @(negedge wb_clk_i) begin
      mon_cycle++;
      if (wb.wbm_cyc_o !== wb.wbm_stb_o) mon_bad++;
      if (wb.wbm_cyc_o && !mon_prev) begin
         mon_start = mon_cycle;
         mon_adr = wb.wbm_adr_o; mon_dat = wb.wbm_dat_o;
         mon_we  = wb.wbm_we_o;  mon_sel = wb.wbm_sel_o;
         mon_stb = 0;
      end else if (wb.wbm_cyc_o && (wb.wbm_adr_o !== mon_adr || wb.wbm_dat_o !== mon_dat ||
                                    wb.wbm_we_o !== mon_we || wb.wbm_sel_o !== mon_sel)) begin
         mon_bad++;
      end
      if (wb.wbm_cyc_o && wb.wbm_stb_o) mon_stb++;
      mon_prev = wb.wbm_cyc_o;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge wb_clk_i);
      #1;
   endtask

   // Reference model of the register map as seen through the initiator.
   logic [31:0] ref_store = 32'h0;
   logic [31:0] ref_fib   = 32'h0;

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a == CTRL_GET_ID)        return CTRL_ID;
      if (a == CTRL_FIBONACCI_VAL) return ref_fib;
      if (a == CTRL_READ)          return ref_store;
      return ~a;
   endfunction

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          delay;
      logic        noack;
      logic [31:0] exp_dat;
      logic        exp_err;
      int          exp_stb;
   } vec_t;

   function automatic void ref_update(input vec_t v);
      if (v.noack) return;
      if (v.we && v.adr == CTRL_WRITE) ref_store = v.dat;
      if (!v.we && v.adr == CTRL_FIBONACCI_VAL) ref_fib = ref_fib + 32'h1;
   endfunction

   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat);
      int n = 0;
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin tick(); n++; end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin tick(); lat++; end
      chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      slv_delay = v.delay; slv_noack = v.noack;
      do_cmd(v.we, v.adr, v.dat, v.sel, lat);
      chk("rsp_dat", rsp_dat, v.exp_dat);
      chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      chk("rsp_poll", 32'(rsp_poll), 32'd0);
      chk("stb_cycles", mon_stb, v.exp_stb);
      chk("latency", lat, v.exp_stb + 1);
      chk("bus_adr", mon_adr, v.adr);
      chk("bus_we", 32'(mon_we), 32'(v.we));
      chk("bus_sel", 32'(mon_sel), 32'(v.sel));
      chk("bus_dat", mon_dat, v.we ? v.dat : 32'h0);
      chk("ready_at_rsp", 32'(cmd_ready), 32'd1);
      chk("cyc_at_rsp", 32'(wb.wbm_cyc_o), 32'd0);
      tick();
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("rsp_hold", rsp_dat, v.exp_dat);
      slv_noack = 1'b0; slv_delay = 0;
      ref_update(v);
   endtask

   task automatic poll_test();
      int c0, prev, n;
      prev = 0;
      poll_en = 1'b1;
      c0 = mon_cycle;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!rsp_valid && n < 60) begin tick(); n++; end
         chk("poll_wait", 32'(rsp_valid), 32'd1);
         chk("poll_flag", 32'(rsp_poll), 32'd1);
         chk("poll_err", 32'(rsp_err), 32'd0);
         chk("poll_dat", rsp_dat, ref_fib);
         ref_fib = ref_fib + 32'h1;
         chk("poll_adr", mon_adr, CTRL_FIBONACCI_VAL);
         chk("poll_sel", 32'(mon_sel), 32'hF);
         chk("poll_we", 32'(mon_we), 32'd0);
         chk("poll_gap", mon_start - ((k == 0) ? c0 : prev), PI);
         prev = mon_start;
         tick();
      end
      poll_en = 1'b0;
      tick(); tick();
   endtask

   task automatic collision_test();
      int lat, c1, n;
      poll_en = 1'b1;
      repeat (PI - 1) tick();
      do_cmd(1'b0, CTRL_GET_ID, 32'h0, 4'hF, lat);
      chk("coll_cmd_poll", 32'(rsp_poll), 32'd0);
      chk("coll_cmd_dat", rsp_dat, CTRL_ID);
      chk("coll_cmd_lat", lat, 2);
      c1 = mon_cycle;
      tick();
      n = 0;
      while (!rsp_valid && n < 40) begin tick(); n++; end
      chk("coll_poll_wait", 32'(rsp_valid), 32'd1);
      chk("coll_poll_flag", 32'(rsp_poll), 32'd1);
      chk("coll_poll_dat", rsp_dat, ref_fib);
      ref_fib = ref_fib + 32'h1;
      chk("coll_poll_start", mon_start, c1 + 1);
      poll_en = 1'b0;
      tick(); tick();
   endtask

   task automatic reset_mid_bus();
      slv_noack = 1'b1;
      cmd_we = 1'b0; cmd_adr = CTRL_FIBONACCI_VAL; cmd_sel = 4'hF; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_cyc_before", 32'(wb.wbm_cyc_o), 32'd1);
      wb_rst_i = 1'b1;
      tick();
      chk("mid_rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
      chk("mid_rst_stb", 32'(wb.wbm_stb_o), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
      chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      wb_rst_i = 1'b0; slv_noack = 1'b0;
      tick();
      chk("mid_ready_after", 32'(cmd_ready), 32'd1);
      chk("mid_rsp_dat", rsp_dat, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
   endtask

   vec_t tbl [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
      cmd_sel = 4'h0; poll_en = 1'b0; slv_noack = 1'b0; slv_spur = 1'b0; slv_delay = 0;

      tbl[0] = '{1'b0, CTRL_GET_ID,        32'h0,         4'hF, 0, 1'b0, CTRL_ID,       1'b0, 1};
      tbl[1] = '{1'b1, CTRL_WRITE,         32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1};
      tbl[2] = '{1'b0, CTRL_READ,          32'h0,         4'hF, 0, 1'b0, 32'hA5A5_0001, 1'b0, 1};
      tbl[3] = '{1'b0, CTRL_FIBONACCI_VAL, 32'h0,         4'hF, 4, 1'b0, 32'h0,         1'b0, 5};
      tbl[4] = '{1'b0, CTRL_PANIC,         32'h0,         4'h1, 0, 1'b1, 32'h0,         1'b1, TO};
      tbl[5] = '{1'b1, CTRL_WRITE,         32'h1234_5678, 4'h3, 2, 1'b0, 32'h0,         1'b0, 3};
      tbl[6] = '{1'b0, CTRL_READ,          32'h0,         4'hC, 0, 1'b0, 32'h1234_5678, 1'b0, 1};
      tbl[7] = '{1'b0, 32'h0000_0040,      32'h0,         4'hF, 1, 1'b0, 32'hFFFF_FFBF, 1'b0, 2};
      tbl[8] = '{1'b0, CTRL_FIBONACCI_VAL, 32'h0,         4'hF, 0, 1'b0, 32'h1,         1'b0, 1};
      tbl[9] = '{1'b1, CTRL_FIBONACCI_CTRL,32'h1,         4'hF, 0, 1'b1, 32'h0,         1'b1, TO};

      repeat (3) tick();
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
      chk("rst_we", 32'(wb.wbm_we_o), 32'd0);
      chk("rst_sel", 32'(wb.wbm_sel_o), 32'd0);
      chk("rst_adr", wb.wbm_adr_o, 32'h0);
      chk("rst_dat_o", wb.wbm_dat_o, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_dat", rsp_dat, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_poll", 32'(rsp_poll), 32'd0);
      wb_rst_i = 1'b0;
      tick();
      chk("release_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      slv_spur = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("spur_cyc", 32'(wb.wbm_cyc_o), 32'd0);
         chk("spur_rsp", 32'(rsp_valid), 32'd0);
      end
      slv_spur = 1'b0;
      tick();

      poll_test();
      collision_test();

      for (int i = 0; i < 40; i++) begin
         v.we  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0:       v.adr = CTRL_GET_ID;
            1:       v.adr = CTRL_FIBONACCI_VAL;
            2:       v.adr = CTRL_WRITE;
            3:       v.adr = CTRL_READ;
            default: v.adr = 32'($urandom_range(16, 255)) << 2;
         endcase
         v.dat     = $urandom;
         v.sel     = 4'($urandom_range(0, 15));
         v.delay   = $urandom_range(0, 3);
         v.noack   = ($urandom_range(0, 7) == 0);
         v.exp_err = v.noack;
         v.exp_stb = v.noack ? TO : v.delay + 1;
         v.exp_dat = (v.we || v.noack) ? 32'h0 : ref_read(v.adr);
         run_vec(v);
      end

      reset_mid_bus();

      chk("bus_stable", mon_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
